h264intra4x4_ctrl: RTL and testbench

H264INTRA4X4_CTRL -- requirements
Module: h264intra4x4_ctrl

---
 rtl/h264intra4x4_pkg.sv | 41 ++++
 rtl/h264intra4x4_modesel.sv | 31 +++
 rtl/h264intra4x4_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_h264intra4x4_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/h264intra4x4_pkg.sv
// Shared types and helpers for the intra 4x4 luma prediction controller.
package h264intra4x4_pkg;

  localparam int SAD_W = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_TOP,
    S_SUM,
    S_EVAL,
    S_DECIDE,
    S_OUT,
    S_FBWAIT,
    S_NEXT
  } state_e;

  typedef enum logic [1:0] {
    MODE_DC  = 2'h0,
    MODE_HOR = 2'h1,
    MODE_VER = 2'h3
  } mode_e;

  // Neighbour availability {tvalid, lvalid} for a z-scan sub-block.
  // Top row of the slice has no upper neighbour; left column of a line/slice
  // start has no left neighbour.
  function automatic logic [1:0] blk_avail(input logic [3:0] sb,
                                           input logic       slice_row,
                                           input logic       left_edge);
    logic [1:0] xx;
    logic [1:0] yy;
    logic       tv;
    logic       lv;
    xx = {sb[2], sb[0]};
    yy = {sb[3], sb[1]};
    tv = !(slice_row && (yy == 2'd0));
    lv = !(left_edge && (xx == 2'd0));
    return {tv, lv};
  endfunction

endpackage

// File: rtl/h264intra4x4_modesel.sv
// Picks the cheapest allowed prediction mode; ties go vertical, then horizontal, then DC.
module h264intra4x4_modesel
  import h264intra4x4_pkg::*;
(
  input  logic [SAD_W-1:0] vtot_i,
  input  logic [SAD_W-1:0] htot_i,
  input  logic [SAD_W-1:0] dtot_i,
  input  logic             tvalid_i,
  input  logic             lvalid_i,
  output logic [1:0]       mode_sel_o
);

  mode_e            mode;
  logic [SAD_W-1:0] best;

  // DC is the fallback; later candidates win on <= so they take ties.
  always_comb begin
    mode = MODE_DC;
    best = dtot_i;
    if (lvalid_i && (htot_i <= best)) begin
      mode = MODE_HOR;
      best = htot_i;
    end
    if (tvalid_i && (vtot_i <= best)) begin
      mode = MODE_VER;
    end
  end

  assign mode_sel_o = mode;

endmodule

// File: rtl/h264intra4x4_ctrl.sv
// Sequencer for one luma macroblock: load 16 words, then per 4x4 sub-block
// predict, evaluate SADs, choose a mode, emit residual rows, await feedback.
module h264intra4x4_ctrl
  import h264intra4x4_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             NEWSLICE,
  input  logic             NEWLINE,
  input  logic             STROBEI,
  output logic             READYI,
  input  logic             FBSTROBE,
  input  logic             READYO,
  input  logic [SAD_W-1:0] VTOTDIF,
  input  logic [SAD_W-1:0] HTOTDIF,
  input  logic [SAD_W-1:0] DTOTDIF,
  output logic [3:0]       SUBMB,
  output logic [1:0]       ROW,
  output logic             TOP_EN,
  output logic             SUM_EN,
  output logic             DIF_CLR,
  output logic             DIF_EN,
  output logic             MODE_EN,
  output logic [1:0]       MODE_SEL,
  output logic [1:0]       SUMSEL,
  output logic             OUTF1_EN,
  output logic             FB_RST,
  output logic             LMODE_EN,
  output logic             XXINC,
  output logic             CHREADY
);

  state_e     state_q;
  logic [4:0] wcnt_q;
  logic [2:0] ecnt_q;
  logic [2:0] fbcnt_q;
  logic       slice_row_q;
  logic       left_edge_q;
  logic [3:0] submb_q;
  logic [1:0] row_q;
  logic       readyi_q;
  logic       top_en_q, sum_en_q, dif_clr_q, dif_en_q, mode_en_q;
  logic       fb_rst_q, lmode_en_q, xxinc_q, chready_q, out_q;
  logic [1:0] sumsel_q;
  logic [1:0] mode_q;
  logic [1:0] msel_w;
  logic       fb_hit;
  logic       in_accept;

  h264intra4x4_modesel u_modesel (
    .vtot_i    (VTOTDIF),
    .htot_i    (HTOTDIF),
    .dtot_i    (DTOTDIF),
    .tvalid_i  (sumsel_q[1]),
    .lvalid_i  (sumsel_q[0]),
    .mode_sel_o(msel_w)
  );

  // Feedback may start arriving while rows are still being emitted.
  assign fb_hit    = FBSTROBE && ((state_q == S_OUT) || (state_q == S_FBWAIT)) &&
                     (fbcnt_q != 3'd4);
  assign in_accept = STROBEI && readyi_q;

  // Sequencer: state, counters and all registered control outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      ecnt_q      <= '0;
      fbcnt_q     <= '0;
      slice_row_q <= 1'b0;
      left_edge_q <= 1'b0;
      submb_q     <= '0;
      row_q       <= '0;
      readyi_q    <= 1'b0;
      top_en_q    <= 1'b0;
      sum_en_q    <= 1'b0;
      dif_clr_q   <= 1'b0;
      dif_en_q    <= 1'b0;
      mode_en_q   <= 1'b0;
      fb_rst_q    <= 1'b0;
      lmode_en_q  <= 1'b0;
      xxinc_q     <= 1'b0;
      chready_q   <= 1'b0;
      out_q       <= 1'b0;
      sumsel_q    <= '0;
      mode_q      <= '0;
    end else begin
      top_en_q   <= 1'b0;
      sum_en_q   <= 1'b0;
      dif_clr_q  <= 1'b0;
      mode_en_q  <= 1'b0;
      fb_rst_q   <= 1'b0;
      lmode_en_q <= 1'b0;
      xxinc_q    <= 1'b0;
      chready_q  <= 1'b0;
      if (fb_hit) fbcnt_q <= fbcnt_q + 3'd1;
      case (state_q)
        S_IDLE: begin
          state_q  <= S_LOAD;
          wcnt_q   <= '0;
          readyi_q <= 1'b1;
        end
        S_LOAD: begin
          if (in_accept) begin
            wcnt_q <= wcnt_q + 5'd1;
            // Slice/line markers only mean something on the first word.
            if (wcnt_q == 5'd0) begin
              left_edge_q <= NEWLINE || NEWSLICE;
              if (NEWSLICE)     slice_row_q <= 1'b1;
              else if (NEWLINE) slice_row_q <= 1'b0;
            end
            if (wcnt_q == 5'd15) begin
              readyi_q <= 1'b0;
              state_q  <= S_TOP;
              top_en_q <= 1'b1;
              fb_rst_q <= 1'b1;
              sumsel_q <= blk_avail(submb_q, slice_row_q, left_edge_q);
            end
          end
        end
        S_TOP: begin
          state_q   <= S_SUM;
          sum_en_q  <= 1'b1;
          dif_clr_q <= 1'b1;
        end
        S_SUM: begin
          state_q <= S_EVAL;
          ecnt_q  <= '0;
          row_q   <= '0;
        end
        S_EVAL: begin
          // Rows 0..3 go out first; SAD accumulation trails by the 3-stage datapath.
          if (ecnt_q == 3'd6) begin
            state_q   <= S_DECIDE;
            mode_en_q <= 1'b1;
            dif_en_q  <= 1'b0;
            row_q     <= '0;
          end else begin
            ecnt_q   <= ecnt_q + 3'd1;
            dif_en_q <= (ecnt_q >= 3'd2);
            if (ecnt_q < 3'd3) row_q <= row_q + 2'd1;
          end
        end
        S_DECIDE: begin
          mode_q  <= msel_w;
          state_q <= S_OUT;
          out_q   <= 1'b1;
          row_q   <= '0;
          fbcnt_q <= '0;
        end
        S_OUT: begin
          if (READYO) begin
            if (row_q == 2'd3) begin
              out_q   <= 1'b0;
              row_q   <= '0;
              state_q <= S_FBWAIT;
            end else begin
              row_q <= row_q + 2'd1;
            end
          end
        end
        S_FBWAIT: begin
          if ((fbcnt_q == 3'd4) || (fb_hit && (fbcnt_q == 3'd3))) begin
            state_q    <= S_NEXT;
            lmode_en_q <= 1'b1;
            if (submb_q == 4'd15) begin
              xxinc_q   <= 1'b1;
              chready_q <= 1'b1;
            end
          end
        end
        S_NEXT: begin
          submb_q <= submb_q + 4'd1;
          if (submb_q == 4'd15) begin
            wcnt_q   <= '0;
            readyi_q <= 1'b1;
            state_q  <= S_LOAD;
          end else begin
            state_q  <= S_TOP;
            top_en_q <= 1'b1;
            fb_rst_q <= 1'b1;
            sumsel_q <= blk_avail(submb_q + 4'd1, slice_row_q, left_edge_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign READYI   = readyi_q;
  assign SUBMB    = submb_q;
  assign ROW      = row_q;
  assign TOP_EN   = top_en_q;
  assign SUM_EN   = sum_en_q;
  assign DIF_CLR  = dif_clr_q;
  assign DIF_EN   = dif_en_q;
  assign MODE_EN  = mode_en_q;
  // Live decision while MODE_EN is up (SADs settle only in that cycle), held afterwards.
  assign MODE_SEL = mode_en_q ? msel_w : mode_q;
  assign SUMSEL   = sumsel_q;
  // Row enable must respond to READYO in the same cycle to avoid issuing into a stall.
  assign OUTF1_EN = out_q && READYO;
  assign FB_RST   = fb_rst_q;
  assign LMODE_EN = lmode_en_q;
  assign XXINC    = xxinc_q;
  assign CHREADY  = chready_q;

endmodule

// File: tb/tb_h264intra4x4_ctrl.sv
// Scoreboard bench for the intra 4x4 controller: a driver issues macroblocks
// and queues expected decisions/rows; a monitor checks what the DUT presents.
module tb_h264intra4x4_ctrl;

  logic        CLK = 1'b0, RSTN = 1'b0;
  logic        NEWSLICE = 1'b0, NEWLINE = 1'b0, STROBEI = 1'b0;
  logic        FBSTROBE = 1'b0, READYO = 1'b0;
  logic [11:0] VTOTDIF = '0, HTOTDIF = '0, DTOTDIF = '0;
  logic        READYI, TOP_EN, SUM_EN, DIF_CLR, DIF_EN, MODE_EN;
  logic        OUTF1_EN, FB_RST, LMODE_EN, XXINC, CHREADY;
  logic [3:0]  SUBMB;
  logic [1:0]  ROW, MODE_SEL, SUMSEL;

  h264intra4x4_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .NEWSLICE(NEWSLICE), .NEWLINE(NEWLINE),
    .STROBEI(STROBEI), .READYI(READYI), .FBSTROBE(FBSTROBE), .READYO(READYO),
    .VTOTDIF(VTOTDIF), .HTOTDIF(HTOTDIF), .DTOTDIF(DTOTDIF),
    .SUBMB(SUBMB), .ROW(ROW), .TOP_EN(TOP_EN), .SUM_EN(SUM_EN),
    .DIF_CLR(DIF_CLR), .DIF_EN(DIF_EN), .MODE_EN(MODE_EN), .MODE_SEL(MODE_SEL),
    .SUMSEL(SUMSEL), .OUTF1_EN(OUTF1_EN), .FB_RST(FB_RST), .LMODE_EN(LMODE_EN),
    .XXINC(XXINC), .CHREADY(CHREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct { int sb; int ss; int md; } exp_t;

  exp_t exp_q[$];
  int   row_q[$];
  int   mb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   first_row = 1'b0;
  bit   left_edge = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({READYI, SUBMB, ROW, TOP_EN, SUM_EN, DIF_CLR, DIF_EN, MODE_EN,
                 MODE_SEL, SUMSEL, OUTF1_EN, FB_RST, LMODE_EN, XXINC, CHREADY});
  endfunction

  // Reference: place the block on the 4x4 grid, then pick the cheapest
  // allowed mode scanning in priority order vertical, horizontal, DC.
  function automatic void model(input int b, input int v, input int h, input int d,
                                output int ss, output int md);
    int col, rw, best;
    bit tv, lv;
    int cost[3];
    int code[3];
    col = (b % 2) + 2 * ((b / 4) % 2);
    rw  = ((b / 2) % 2) + 2 * (b / 8);
    tv  = !(first_row && rw == 0);
    lv  = !(left_edge && col == 0);
    ss  = (tv ? 2 : 0) + (lv ? 1 : 0);
    cost[0] = tv ? v : 1 << 20;  code[0] = 3;
    cost[1] = lv ? h : 1 << 20;  code[1] = 1;
    cost[2] = d;                 code[2] = 0;
    best = 0;
    for (int i = 1; i < 3; i++) if (cost[i] < cost[best]) best = i;
    md = code[best];
  endfunction

  function automatic logic [11:0] rsad();
    case ($urandom_range(0, 3))
      0:       return 12'd40;
      1:       return 12'd4095;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT presents a decision, row or MB end.
  initial begin
    bit   after = 1'b0;
    bit   prev_dif = 1'b0;
    int   lm = 0;
    int   dif = 0;
    int   r;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        after = 1'b0; prev_dif = 1'b0; lm = 0; dif = 0;
        continue;
      end
      if (after) begin
        chk("mb_end_submb", int'(SUBMB), 0);
        chk("mb_end_readyi", int'(READYI), 1);
        after = 1'b0;
      end
      if (DIF_CLR) dif = 0;
      if (MODE_EN) begin
        chk("dif_en_count", dif, 4);
        chk("dif_en_before_decide", int'(prev_dif), 1);
        chk("mode_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("submb", int'(SUBMB), e.sb);
          chk("sumsel", int'(SUMSEL), e.ss);
          chk("mode_sel", int'(MODE_SEL), e.md);
        end
      end
      if (OUTF1_EN) begin
        chk("row_pending", int'(row_q.size() > 0), 1);
        if (row_q.size() > 0) begin
          r = row_q.pop_front();
          chk("out_row", int'(ROW), r);
        end
      end
      if (LMODE_EN) lm++;
      if (XXINC) begin
        chk("chready_with_xxinc", int'(CHREADY), 1);
        chk("lmode_count", lm, 16);
        chk("mb_pending", int'(mb_q.size() > 0), 1);
        if (mb_q.size() > 0) r = mb_q.pop_front();
        after = 1'b1;
        lm = 0;
      end else if (CHREADY) begin
        chk("chready_alone", int'(CHREADY), 0);
      end
      prev_dif = DIF_EN;
      if (DIF_EN) dif++;
    end
  end

  task automatic load_mb(input bit ns, input bit nl);
    int n = 0, cyc = 0;
    while (n < 16 && cyc < 300) begin
      @(posedge CLK); #1;
      STROBEI  = ($urandom_range(0, 3) != 0);
      NEWSLICE = (n == 0) ? ns : 1'($urandom_range(0, 1));
      NEWLINE  = (n == 0) ? nl : 1'($urandom_range(0, 1));
      if (STROBEI && READYI) n++;
      cyc++;
    end
    chk("load_words", n, 16);
  endtask

  // STROBEI is left high after the 16th word so that it must be ignored until here.
  task automatic wait_sum();
    int cyc = 0;
    do begin @(negedge CLK); cyc++; end while (!DIF_CLR && cyc < 60);
    chk("difclr_seen", int'(DIF_CLR), 1);
    STROBEI = 1'b0; NEWSLICE = 1'b0; NEWLINE = 1'b0;
  endtask

  task automatic run_sub(input int b, input logic [11:0] v, input logic [11:0] h,
                         input logic [11:0] d, input bit stall);
    int cyc = 0, rows = 0, sc = 0, sent = 0;
    bit early;
    exp_t e;
    wait_sum();
    VTOTDIF = v; HTOTDIF = h; DTOTDIF = d;
    e.sb = b;
    model(b, int'(v), int'(h), int'(d), e.ss, e.md);
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) row_q.push_back(i);
    early = 1'($urandom_range(0, 1));
    while (rows < 4 && cyc < 200) begin
      @(posedge CLK); #1;
      if (stall && rows == 1 && sc < 5) READYO = 1'b0;
      else READYO = ($urandom_range(0, 3) != 0);
      FBSTROBE = early && rows == 3 && sent == 0;
      if (FBSTROBE) sent = 1;
      @(negedge CLK);
      if (stall && rows == 1 && sc < 5) begin
        chk("stall_row", int'(ROW), 1);
        chk("stall_outf1", int'(OUTF1_EN), 0);
        sc++;
      end
      if (OUTF1_EN) rows++;
      cyc++;
    end
    chk("rows_out", rows, 4);
    while (sent < 4) begin
      @(posedge CLK); #1;
      FBSTROBE = 1'($urandom_range(0, 1));
      if (FBSTROBE) sent++;
    end
    @(posedge CLK); #1;
    FBSTROBE = 1'b0; READYO = 1'b0;
  endtask

  task automatic reset_mid();
    wait_sum();
    repeat (3) @(negedge CLK);
    @(posedge CLK); #3;
    exp_q.delete(); row_q.delete(); mb_q.delete();
    RSTN = 1'b0;
    READYO = 1'b1;
    #1 chk("async_reset_outputs", outs(), 0);
    READYO = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    @(negedge CLK); chk("post_rst_idle_readyi", int'(READYI), 0);
    @(negedge CLK);
    chk("post_rst_load_readyi", int'(READYI), 1);
    chk("post_rst_submb", int'(SUBMB), 0);
    chk("post_rst_xxinc", int'(XXINC), 0);
  endtask

  // mode 0: random SADs; 1: directed tie/DC cases plus a READYO stall; 2: reset in sub-block 5.
  task automatic run_mb(input bit ns, input bit nl, input int mode);
    logic [11:0] v, h, d;
    if (ns) first_row = 1'b1;
    else if (nl) first_row = 1'b0;
    left_edge = ns || nl;
    if (mode != 2) mb_q.push_back(1);
    load_mb(ns, nl);
    for (int b = 0; b < 16; b++) begin
      v = rsad(); h = rsad(); d = rsad();
      if (mode == 1 && b == 1) begin v = 12'd40; h = 12'd40; d = 12'd10; end
      if (mode == 1 && b == 3) begin v = 12'd40; h = 12'd40; d = 12'd40; end
      if (mode == 2 && b == 5) begin
        reset_mid();
        return;
      end
      run_sub(b, v, h, d, mode == 1 && b == 2);
    end
  endtask

  initial begin
    RSTN = 1'b0; READYO = 1'b1; STROBEI = 1'b1;
    VTOTDIF = 12'h123; HTOTDIF = 12'h456; DTOTDIF = 12'h789;
    #2 chk("reset_outputs", outs(), 0);
    READYO = 1'b0; STROBEI = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    @(negedge CLK); chk("idle_readyi", int'(READYI), 0);
    @(negedge CLK); chk("load_readyi", int'(READYI), 1);
    run_mb(1'b1, 1'b1, 0);
    run_mb(1'b0, 1'b0, 0);
    run_mb(1'b0, 1'b1, 1);
    run_mb(1'b0, 1'b0, 0);
    run_mb(1'b0, 1'b0, 2);
    run_mb(1'b1, 1'b1, 0);
    run_mb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    run_mb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    repeat (10) @(negedge CLK);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("row_q_drained", row_q.size(), 0);
    chk("mb_q_drained", mb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
